// File: rtl/max_pool_1_engine.sv
// 2x2 stride-2 signed max-pooling engine: conv_1 BRAM -> max_pool_1 BRAM, one output per 6 cycles.
// Optional build macro MAX_POOL_1_RELU_EN clamps negative pooled values to zero before the write.
module max_pool_1_engine #(
    parameter int IN_W     = 32,
    parameter int IN_H     = 32,
    parameter int CHANNELS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] src_addr,
    output logic        src_en,
    input  logic [31:0] src_dout,
    output logic [31:0] dst_addr,
    output logic [31:0] dst_din,
    output logic        dst_en,
    output logic [3:0]  dst_we
);

    localparam logic [31:0] OUT_W     = 32'(IN_W / 2);
    localparam logic [31:0] OUT_H     = 32'(IN_H / 2);
    localparam logic [31:0] ROW_IN    = 32'(IN_W);
    localparam logic [31:0] PLANE_IN  = 32'(IN_W * IN_H);
    localparam logic [31:0] PLANE_OUT = 32'((IN_W / 2) * (IN_H / 2));
    localparam logic [31:0] LAST_C    = 32'(CHANNELS - 1);

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, LAST, WR, DONE} state_t;

    state_t             state;
    logic [31:0]        ox, oy, c;
    logic [31:0]        ox_n, oy_n, c_n;
    logic               final_out;
    logic signed [31:0] max_val;
    logic signed [31:0] cmp_max;
    logic signed [31:0] pooled;

    function automatic logic [31:0] src_byte(input logic [31:0] ch, input logic [31:0] y,
                                             input logic [31:0] x);
        return (ch * PLANE_IN + y * ROW_IN + x) << 2;
    endfunction

    always_comb begin
        final_out = (c == LAST_C) && (oy == OUT_H - 1) && (ox == OUT_W - 1);
        ox_n = ox + 1;
        oy_n = oy;
        c_n  = c;
        if (ox == OUT_W - 1) begin
            ox_n = '0;
            oy_n = oy + 1;
            if (oy == OUT_H - 1) begin
                oy_n = '0;
                c_n  = c + 1;
            end
        end
        cmp_max = ($signed(src_dout) > max_val) ? $signed(src_dout) : max_val;
`ifdef MAX_POOL_1_RELU_EN
        pooled = cmp_max[31] ? '0 : cmp_max;
`else
        pooled = cmp_max;
`endif
    end

    // Outputs are loaded for the state being entered, so each state's signals appear in its own cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            src_en   <= 1'b0;
            src_addr <= '0;
            dst_en   <= 1'b0;
            dst_we   <= '0;
            dst_addr <= '0;
            dst_din  <= '0;
            ox       <= '0;
            oy       <= '0;
            c        <= '0;
            max_val  <= '0;
        end else begin
            done   <= 1'b0;
            dst_en <= 1'b0;
            dst_we <= '0;
            case (state)
                IDLE: if (start) begin
                    state    <= RD0;
                    ox       <= '0;
                    oy       <= '0;
                    c        <= '0;
                    busy     <= 1'b1;
                    src_en   <= 1'b1;
                    src_addr <= '0;
                end
                RD0: begin
                    state    <= RD1;
                    src_addr <= src_byte(c, 2 * oy, 2 * ox + 1);
                end
                RD1: begin
                    state    <= RD2;
                    max_val  <= src_dout;
                    src_addr <= src_byte(c, 2 * oy + 1, 2 * ox);
                end
                RD2: begin
                    state    <= RD3;
                    max_val  <= cmp_max;
                    src_addr <= src_byte(c, 2 * oy + 1, 2 * ox + 1);
                end
                RD3: begin
                    state   <= LAST;
                    max_val <= cmp_max;
                    src_en  <= 1'b0;
                end
                LAST: begin
                    state    <= WR;
                    max_val  <= cmp_max;
                    dst_en   <= 1'b1;
                    dst_we   <= 4'hF;
                    dst_addr <= (c * PLANE_OUT + oy * OUT_W + ox) << 2;
                    dst_din  <= pooled;
                end
                WR: begin
                    if (final_out) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= RD0;
                        ox       <= ox_n;
                        oy       <= oy_n;
                        c        <= c_n;
                        src_en   <= 1'b1;
                        src_addr <= src_byte(c_n, 2 * oy_n, 2 * ox_n);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/max_pool_1_engine.md
# max_pool_1_engine

Sequential 2x2, stride-2 max-pooling engine for the first pooling stage of the CIFAR-10 CNN accelerator. It reads conv_1 feature maps from the conv_1 output BRAM through a read-only port. It computes the signed maximum of each 2x2 window and writes each result into the max_pool_1 BRAM through its port A. Software or the layer sequencer starts it with a start pulse; it reports completion with a done pulse.

## Interface
- IN_W, 32: input feature-map width; must be even.
- IN_H, 32: input feature-map height; must be even.
- CHANNELS, 32: number of channels.
- clk  input  1  single clock for all logic and both BRAM ports.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- busy  output  1  high while pooling is in progress.
- done  output  1  one-cycle completion pulse.
- src_addr  output  32  conv_1 BRAM byte address (word index << 2).
- src_en  output  1  conv_1 BRAM read enable.
- src_dout  input  32  conv_1 BRAM read data; valid 1 cycle after src_en.
- dst_addr  output  32  max_pool_1 BRAM port A byte address.
- dst_din  output  32  max_pool_1 BRAM port A write data.
- dst_en  output  1  max_pool_1 BRAM port A enable.
- dst_we  output  4  max_pool_1 BRAM port A byte write enables.

## Operation
- **Data format:** one element per 32-bit word, signed two's complement (Q16.16). All comparisons are signed.
- **Output size:** OUT_W = IN_W/2, OUT_H = IN_H/2, N = OUT_W*OUT_H*CHANNELS outputs.
- **Source word index:** c*IN_H*IN_W + y*IN_W + x.
- **Destination word index:** c*OUT_H*OUT_W + oy*OUT_W + ox.
- **Addresses:** byte address = index << 2; bits [1:0] are always 0.
- **Iteration order:** c outermost, then oy, then ox innermost. Counters are registered; ox wraps to 0 and increments oy, and oy wraps to 0 and increments c.
- **FSM states:** IDLE, RD0, RD1, RD2, RD3, LAST, WR, DONE.
- **IDLE:** start=1 goes to RD0 with all counters cleared.
- **RD0..RD3:** each asserts src_en=1 and issues one address, in this order:
  - RD0: (2ox, 2oy)
  - RD1: (2ox+1, 2oy)
  - RD2: (2ox, 2oy+1)
  - RD3: (2ox+1, 2oy+1)
- **Running max:**
  - In RD1, max is loaded with src_dout (the RD0 data).
  - In RD2, RD3 and LAST, max = (src_dout > max) ? src_dout : max.
  - LAST asserts src_en=0.
- **WR:** drives dst_en=1, dst_we=4'hF, dst_addr = destination byte address, dst_din = pooled value.
  - After the final output (c=CHANNELS-1, oy=OUT_H-1, ox=OUT_W-1), the next state is DONE.
  - Otherwise the counters advance and the next state is RD0.
- **DONE:** done=1 for one cycle, then IDLE.
- **start while busy:** ignored; no restart and no queueing.
- **Enables when idle:** src_en, dst_en and dst_we are 0 in every state not listed above as asserting them.
- **Reset values (asynchronous, rst_n=0):** state=IDLE; busy=0, done=0, src_en=0, src_addr=0, dst_en=0, dst_we=0, dst_addr=0, dst_din=0. Counters and max are also reset to 0.
- **Reset mid-operation:** the FSM aborts immediately. Words already written stay in the max_pool_1 BRAM, and no done pulse is produced.

## Timing
- Start is sampled in cycle 0. RD0 is cycle 1; busy rises in cycle 1.
- Each output takes exactly 6 cycles (RD0, RD1, RD2, RD3, LAST, WR).
- The k-th write (k = 1..N) occurs in cycle 6k.
- done=1 and busy=0 in cycle 6N+1. Busy is high in cycles 1..6N inclusive.
- A new start is accepted in cycle 6N+2 at the earliest.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- src_dout is consumed exactly one cycle after the corresponding src_en; the source BRAM has fixed latency 1 and no output register.

## Configuration
- MAX_POOL_1_RELU_EN defined: dst_din = (max < 0) ? 0 : max, which fuses ReLU after pooling.
- MAX_POOL_1_RELU_EN undefined: dst_din = max unchanged; negative values are written as-is.
- Timing is identical in both builds.

## Test plan
- **Basic pooling:** IN_W=4, IN_H=4, CHANNELS=1, source words 0..15 in raster order; pulse start.
  - Required writes: 5, 7, 13, 15 at dst_addr 0x0, 0x4, 0x8, 0xC.
  - Write cycles: 6, 12, 18, 24.
  - done in cycle 25.
- **Signed compare and ReLU:** single window {-8, -3, -5, -20}.
  - Without MAX_POOL_1_RELU_EN: write 0xFFFFFFFD (-3).
  - With MAX_POOL_1_RELU_EN: write 0x00000000.
- **Multi-channel addressing:** 4x4x2, channel-1 words = 100 + i.
  - Second-channel writes are 105, 107, 113, 115 at dst_addr 0x10..0x1C.
  - Source addresses for channel 1 start at 0x40.
- **start while busy:** pulse start again at cycle 3 and cycle 10 of a 4x4x1 run.
  - Exactly 4 writes and one done pulse, in cycle 25.
  - No extra writes after that.
- **Reset mid-run:** assert rst_n=0 at cycle 14 (between the 2nd and 3rd writes).
  - All outputs go to 0 immediately.
  - After release and a new start, the full 4x4x1 sequence repeats correctly.
- **Idle quiescence:** no start for 50 cycles after reset.
  - src_en, dst_en, dst_we, busy and done stay 0 throughout.
